bit_destuff: RTL and testbench

//   Receive-side bit de-stuffer for the serial bit-stuffing link. It deletes the
//   0 that the transmitter inserts after every RUN_LEN consecutive 1s.
//   It flags a stuffing violation, forwards destuffed bits, packs them LSB-first

---
 rtl/bit_destuff_if.sv | 26 ++
 rtl/bit_destuff.sv | 130 +++++++++++++
 tb/tb_bit_destuff.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bit_destuff_if.sv
// Serial link bundle between line sampler, bit de-stuffer and frame parser.
// The sampler side drives valid_in/data_in; the de-stuffer drives the decoded outputs.
interface bit_destuff_if #(parameter int CNT_W = 16);
  logic             valid_in;
  logic             data_in;
  logic             bit_out;
  logic             bit_valid;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic [3:0]       byte_bits;
  logic             frame_done;
  logic [CNT_W-1:0] frame_len;
  logic             stuff_err;

  modport master (
    output valid_in, data_in,
    input  bit_out, bit_valid, byte_out, byte_valid, byte_bits,
           frame_done, frame_len, stuff_err
  );

  modport slave (
    input  valid_in, data_in,
    output bit_out, bit_valid, byte_out, byte_valid, byte_bits,
           frame_done, frame_len, stuff_err
  );
endinterface

// File: rtl/bit_destuff.sv
// Receive-side bit de-stuffer: drops the stuff 0 after RUN_LEN ones, flags
// violations, packs destuffed bits LSB-first into bytes and reports frame length.
//
// state | meaning
// SYNC  | after reset, wait for valid_in low so no partial frame is decoded
// IDLE  | between frames, first valid bit starts a frame
// RUN   | passing destuffed bits
// DROP  | RUN_LEN ones seen, next bit must be the stuff 0
// ERR   | stuffing violation, discard until valid_in falls
module bit_destuff #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  bit_destuff_if.slave bus
);
  localparam int ONES_W = $clog2(RUN_LEN + 1);

  typedef enum logic [2:0] {SYNC, IDLE, RUN, DROP, ERR} state_t;

  state_t            state;
  logic [ONES_W-1:0] ones_cnt;
  logic [ONES_W-1:0] ones_inc;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [7:0]        shreg_nxt;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              take_bit;
  logic              end_frame;

  logic              bit_out_r;
  logic              bit_valid_r;
  logic [7:0]        byte_out_r;
  logic              byte_valid_r;
  logic [3:0]        byte_bits_r;
  logic              frame_done_r;
  logic [CNT_W-1:0]  frame_len_r;
  logic              stuff_err_r;

  always_comb begin
    take_bit  = bus.valid_in && (state == IDLE || state == RUN);
    end_frame = !bus.valid_in && (state == RUN || state == DROP);
    ones_inc  = bus.data_in ? ones_cnt + 1'b1 : '0;
    shreg_nxt = shreg | (8'(bus.data_in) << bit_idx);
    cnt_inc   = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      ones_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      frame_cnt    <= '0;
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      byte_out_r   <= '0;
      byte_valid_r <= 1'b0;
      byte_bits_r  <= '0;
      frame_done_r <= 1'b0;
      frame_len_r  <= '0;
      stuff_err_r  <= 1'b0;
    end else begin
      bit_valid_r  <= 1'b0;
      byte_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      stuff_err_r  <= 1'b0;
      if (take_bit) begin
        bit_valid_r <= 1'b1;
        bit_out_r   <= bus.data_in;
        frame_cnt   <= cnt_inc;
        ones_cnt    <= ones_inc;
        state       <= (ones_inc == ONES_W'(RUN_LEN)) ? DROP : RUN;
        if (bit_idx == 3'd7) begin
          byte_out_r   <= shreg_nxt;
          byte_bits_r  <= 4'd8;
          byte_valid_r <= 1'b1;
          shreg        <= '0;
          bit_idx      <= '0;
        end else begin
          shreg   <= shreg_nxt;
          bit_idx <= bit_idx + 1'b1;
        end
      end else if (end_frame) begin
        // a frame ending in DROP simply lacks its trailing stuff 0; not an error
        frame_done_r <= 1'b1;
        frame_len_r  <= frame_cnt;
        frame_cnt    <= '0;
        ones_cnt     <= '0;
        shreg        <= '0;
        bit_idx      <= '0;
        state        <= IDLE;
        if (bit_idx != 3'd0) begin
          byte_valid_r <= 1'b1;
          byte_out_r   <= shreg;
          byte_bits_r  <= {1'b0, bit_idx};
        end
      end else begin
        case (state)
          SYNC, ERR: if (!bus.valid_in) state <= IDLE;
          DROP: begin
            if (bus.data_in) begin
              stuff_err_r <= 1'b1;
              ones_cnt    <= '0;
              shreg       <= '0;
              bit_idx     <= '0;
              frame_cnt   <= '0;
              state       <= ERR;
            end else begin
              ones_cnt <= '0;
              state    <= RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.bit_out    = bit_out_r;
  assign bus.bit_valid  = bit_valid_r;
  assign bus.byte_out   = byte_out_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.byte_bits  = byte_bits_r;
  assign bus.frame_done = frame_done_r;
  assign bus.frame_len  = frame_len_r;
  assign bus.stuff_err  = stuff_err_r;
endmodule

// File: tb/tb_bit_destuff.sv
// Directed bench for bit_destuff: per-cycle vector table plus hand sequences
// for the 11-bit frame and mid-frame reset.
module tb_bit_destuff;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  bit_destuff_if #(.CNT_W(16)) bus ();

  bit_destuff #(.RUN_LEN(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        v;
    logic        d;
    logic        bv;
    logic        bo;
    logic        yv;
    logic [7:0]  yo;
    logic [3:0]  yb;
    logic        fd;
    logic [15:0] fl;
    logic        se;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, v, d, bv, bo, yv, input logic [7:0] yo,
                              input logic [3:0] yb, input logic fd, input logic [15:0] fl,
                              input logic se);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.bv = bv; t.bo = bo; t.yv = yv;
    t.yo = yo; t.yb = yb; t.fd = fd; t.fl = fl; t.se = se;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, v, d, bv, bo, yv, input logic [7:0] yo,
                      input logic [3:0] yb, input logic fd, input logic [15:0] fl,
                      input logic se);
    rst = r;
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    cyc++;
    chk("bit_valid", 32'(bus.bit_valid), 32'(bv));
    if (bv) chk("bit_out", 32'(bus.bit_out), 32'(bo));
    chk("byte_valid", 32'(bus.byte_valid), 32'(yv));
    chk("byte_out", 32'(bus.byte_out), 32'(yo));
    chk("byte_bits", 32'(bus.byte_bits), 32'(yb));
    chk("frame_done", 32'(bus.frame_done), 32'(fd));
    chk("frame_len", 32'(bus.frame_len), 32'(fl));
    chk("stuff_err", 32'(bus.stuff_err), 32'(se));
  endtask

  logic [10:0] pat11;

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;

    // reset and SYNC -> IDLE
    add(1,0,0, 0,0,0,8'h00,0, 0,0,0);
    add(1,0,0, 0,0,0,8'h00,0, 0,0,0);
    add(0,0,0, 0,0,0,8'h00,0, 0,0,0);
    // stuffed frame 1,1,1,1,0,1 -> five ones, partial byte 0x1F
    add(0,1,1, 1,1,0,8'h00,0, 0,0,0);
    add(0,1,1, 1,1,0,8'h00,0, 0,0,0);
    add(0,1,1, 1,1,0,8'h00,0, 0,0,0);
    add(0,1,1, 1,1,0,8'h00,0, 0,0,0);
    add(0,1,0, 0,0,0,8'h00,0, 0,0,0);
    add(0,1,1, 1,1,0,8'h00,0, 0,0,0);
    add(0,0,0, 0,0,1,8'h1F,5, 1,5,0);
    // violation 1,1,1,1,1,0
    add(0,1,1, 1,1,0,8'h1F,5, 0,5,0);
    add(0,1,1, 1,1,0,8'h1F,5, 0,5,0);
    add(0,1,1, 1,1,0,8'h1F,5, 0,5,0);
    add(0,1,1, 1,1,0,8'h1F,5, 0,5,0);
    add(0,1,1, 0,0,0,8'h1F,5, 0,5,1);
    add(0,1,0, 0,0,0,8'h1F,5, 0,5,0);
    add(0,0,0, 0,0,0,8'h1F,5, 0,5,0);
    // 0xA5 LSB-first, full byte on 8th bit, no extra byte at end
    add(0,1,1, 1,1,0,8'h1F,5, 0,5,0);
    add(0,1,0, 1,0,0,8'h1F,5, 0,5,0);
    add(0,1,1, 1,1,0,8'h1F,5, 0,5,0);
    add(0,1,0, 1,0,0,8'h1F,5, 0,5,0);
    add(0,1,0, 1,0,0,8'h1F,5, 0,5,0);
    add(0,1,1, 1,1,0,8'h1F,5, 0,5,0);
    add(0,1,0, 1,0,0,8'h1F,5, 0,5,0);
    add(0,1,1, 1,1,1,8'hA5,8, 0,5,0);
    add(0,0,0, 0,0,0,8'hA5,8, 1,8,0);
    // frame A = 1,1,1; one idle cycle; frame B = 1,1,0
    add(0,1,1, 1,1,0,8'hA5,8, 0,8,0);
    add(0,1,1, 1,1,0,8'hA5,8, 0,8,0);
    add(0,1,1, 1,1,0,8'hA5,8, 0,8,0);
    add(0,0,0, 0,0,1,8'h07,3, 1,3,0);
    add(0,1,1, 1,1,0,8'h07,3, 0,3,0);
    add(0,1,1, 1,1,0,8'h07,3, 0,3,0);
    add(0,1,0, 1,0,0,8'h07,3, 0,3,0);
    add(0,0,0, 0,0,1,8'h03,3, 1,3,0);
    // frame ending in DROP without its stuff 0 is legal
    add(0,1,1, 1,1,0,8'h03,3, 0,3,0);
    add(0,1,1, 1,1,0,8'h03,3, 0,3,0);
    add(0,1,1, 1,1,0,8'h03,3, 0,3,0);
    add(0,1,1, 1,1,0,8'h03,3, 0,3,0);
    add(0,0,0, 0,0,1,8'h0F,4, 1,4,0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].bv, vecs[i].bo, vecs[i].yv,
           vecs[i].yo, vecs[i].yb, vecs[i].fd, vecs[i].fl, vecs[i].se);

    // 11-bit unstuffed frame: byte 0x96 at bit 8, then 3-bit tail 0x05 with frame_done
    pat11 = 11'b101_1001_0110;
    for (int i = 0; i < 11; i++) begin
      if (i == 7)
        step(0,1,pat11[i], 1,pat11[i],1,8'h96,8, 0,4,0);
      else if (i < 7)
        step(0,1,pat11[i], 1,pat11[i],0,8'h0F,4, 0,4,0);
      else
        step(0,1,pat11[i], 1,pat11[i],0,8'h96,8, 0,4,0);
    end
    step(0,0,0, 0,0,1,8'h05,3, 1,11,0);

    // reset mid-frame with valid_in held high: nothing decoded until valid_in drops
    step(0,1,1, 1,1,0,8'h05,3, 0,11,0);
    step(0,1,1, 1,1,0,8'h05,3, 0,11,0);
    step(1,1,1, 0,0,0,8'h00,0, 0,0,0);
    for (int i = 0; i < 5; i++)
      step(0,1,1, 0,0,0,8'h00,0, 0,0,0);
    step(0,1,0, 0,0,0,8'h00,0, 0,0,0);
    step(0,0,0, 0,0,0,8'h00,0, 0,0,0);
    step(0,1,1, 1,1,0,8'h00,0, 0,0,0);
    step(0,1,0, 1,0,0,8'h00,0, 0,0,0);
    step(0,1,1, 1,1,0,8'h00,0, 0,0,0);
    step(0,0,0, 0,0,1,8'h05,3, 1,3,0);
    step(0,0,0, 0,0,0,8'h05,3, 0,3,0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
